adc_sample_packer: RTL and testbench

Downstream consumer of the ADC emulator's 16-bit sample stream. Packs consecutive samples into 64-bit words, buffers them in a small FIFO and presents them as a valid/ready stream with packet framing (`m_last`) to the DMA write engine. Detects and counts back-pressure overflow without stalling the sample source, which has no ready input.

---
 rtl/adc_stream_pkg.sv | 14 +
 rtl/adc_pack_fifo.sv | 75 +++++++
 rtl/adc_sample_packer.sv | 104 ++++++++++
 tb/tb_adc_sample_packer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_stream_pkg.sv
// Shared definitions for the ADC sample stream: default widths and the
// word-plus-framing record handed from the packer to the DMA write engine.
package adc_stream_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_LANES    = 4;
    localparam int DEF_WORD_W   = DEF_SAMPLE_W * DEF_LANES;

    typedef struct packed {
        logic                  last;
        logic [DEF_WORD_W-1:0] word;
    } word_last_t;

endpackage

// File: rtl/adc_pack_fifo.sv
// First-word-fall-through FIFO with a registered head word; total capacity is
// DEPTH entries (head register plus ring body).
module adc_pack_fifo #(
    parameter int DATA_W = 65,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    body_cnt;
    logic              head_valid;
    logic [DATA_W-1:0] head_q;
    logic              pop, push, head_free, body_empty, body_wr, body_rd;

    assign full       = (body_cnt + {{PTR_W{1'b0}}, head_valid}) == FULL_CNT;
    assign pop        = head_valid && rd_en;
    assign push       = wr_en && (!full || pop);
    assign head_free  = !head_valid || pop;
    assign body_empty = (body_cnt == '0);
    // A push bypasses the body only when the head is being vacated and nothing is queued behind it.
    assign body_wr    = push && !(head_free && body_empty);
    assign body_rd    = head_free && !body_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_valid <= 1'b0;
            head_q     <= '0;
        end else if (head_free) begin
            if (!body_empty) begin
                head_q     <= mem[rd_ptr];
                head_valid <= 1'b1;
            end else if (push) begin
                head_q     <= wr_data;
                head_valid <= 1'b1;
            end else begin
                head_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            body_cnt <= '0;
        end else begin
            if (body_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (body_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({body_wr, body_rd})
                2'b10:   body_cnt <= body_cnt + (PTR_W+1)'(1);
                2'b01:   body_cnt <= body_cnt - (PTR_W+1)'(1);
                default: body_cnt <= body_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (body_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = head_q;
    assign empty   = !head_valid;

endmodule

// File: rtl/adc_sample_packer.sv
// Packs consecutive ADC samples into wide words, frames them into packets and
// streams them out through a FIFO, counting words lost to back-pressure.
module adc_sample_packer
    import adc_stream_pkg::*;
#(
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int LANES      = DEF_LANES,
    parameter int PKT_WORDS  = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [SAMPLE_W-1:0]       smp_data,
    input  logic                      smp_valid,
    output logic [SAMPLE_W*LANES-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);
    localparam int WORD_W = SAMPLE_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PKT_WORDS - 1);

    logic [LANE_W-1:0]                lane_cnt;
    logic [LANES-1:0][SAMPLE_W-1:0]   lanes_q, assembled;
    logic [WORD_W-1:0]                word_q;
    logic                             push_req;
    logic [IDX_W-1:0]                 word_idx;
    logic                             fifo_full, fifo_empty, pop, drop, store;
    logic [WORD_W:0]                  fifo_dout;

    always_comb begin
        assembled           = lanes_q;
        assembled[lane_cnt] = smp_data;
    end

    // Dropping enable simply rewinds the lane counter; stale lanes are overwritten before reuse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt <= '0;
            lanes_q  <= '0;
            word_q   <= '0;
            push_req <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (!enable) begin
                lane_cnt <= '0;
            end else if (smp_valid) begin
                lanes_q <= assembled;
                if (lane_cnt == LAST_LANE) begin
                    lane_cnt <= '0;
                    word_q   <= assembled;
                    push_req <= 1'b1;
                end else begin
                    lane_cnt <= lane_cnt + LANE_W'(1);
                end
            end
        end
    end

    assign pop   = m_valid && m_ready;
    assign drop  = push_req && fifo_full && !pop;
    assign store = push_req && !drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (store) begin
                word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + IDX_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    adc_pack_fifo #(
        .DATA_W (WORD_W + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_req),
        .wr_data ({word_idx == LAST_IDX, word_q}),
        .full    (fifo_full),
        .rd_en   (m_ready),
        .rd_data (fifo_dout),
        .empty   (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_dout[WORD_W-1:0];
    assign m_last  = fifo_dout[WORD_W];

endmodule

// File: tb/tb_adc_sample_packer.sv
// Randomised and directed bench for adc_sample_packer: a queue-based packet model
// predicts stored words and drops, and a negedge monitor checks the output stream.
module tb_adc_sample_packer;
    localparam int SAMPLE_W   = 16;
    localparam int LANES      = 4;
    localparam int PKT_WORDS  = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int WORD_W     = SAMPLE_W * LANES;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic                smp_valid = 1'b0;
    logic                m_ready = 1'b0;
    logic [SAMPLE_W-1:0] smp_data = '0;
    logic [WORD_W-1:0]   m_data;
    logic                m_valid;
    logic                m_last;
    logic                overflow;
    logic [15:0]         drop_cnt;

    int num_checks = 0;
    int num_errors = 0;

    adc_sample_packer #(
        .SAMPLE_W   (SAMPLE_W),
        .LANES      (LANES),
        .PKT_WORDS  (PKT_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic vld, input logic [15:0] data, input logic rdy);
        @(posedge clk);
        #1;
        enable    = en;
        smp_valid = vld;
        smp_data  = data;
        m_ready   = rdy;
    endtask

    // Reference model: samples gather into a word; a completed word is offered one edge later
    // to a FIFO of FIFO_DEPTH words whose contents are exp_q.
    typedef struct {
        logic [WORD_W-1:0] word;
        logic              last;
    } exp_t;

    exp_t              exp_q[$];
    logic [15:0]       part[$];
    logic [WORD_W-1:0] pend_word;
    bit                pend = 0;
    int                model_idx = 0;
    bit                model_ovf = 0;
    int                model_drops = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            part.delete();
            pend        = 0;
            model_idx   = 0;
            model_ovf   = 0;
            model_drops = 0;
        end else begin
            // exp_q already reflects the pop the monitor took for this edge.
            if (pend) begin
                if (exp_q.size() >= FIFO_DEPTH) begin
                    model_ovf = 1;
                    if (model_drops < 65535) model_drops++;
                end else begin
                    exp_q.push_back('{pend_word, model_idx == PKT_WORDS - 1});
                    model_idx = (model_idx + 1) % PKT_WORDS;
                end
                pend = 0;
            end
            if (!enable) begin
                part.delete();
            end else if (smp_valid) begin
                part.push_back(smp_data);
                if (part.size() == LANES) begin
                    pend_word = '0;
                    for (int k = 0; k < LANES; k++) pend_word[k*SAMPLE_W +: SAMPLE_W] = part[k];
                    pend = 1;
                    part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
        checkOutput("overflow", 64'(overflow), 64'(model_ovf));
        checkOutput("drop_cnt", 64'(drop_cnt), 64'(model_drops));
        if (m_valid && exp_q.size() != 0) begin
            checkOutput("m_data", m_data, exp_q[0].word);
            checkOutput("m_last", 64'(m_last), 64'(exp_q[0].last));
            if (m_ready) void'(exp_q.pop_front());
        end
    end

    logic [15:0] ramp;

    initial begin
        ramp = 16'd0;
        #12;
        checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
        checkOutput("reset_m_data", m_data, 64'd0);
        checkOutput("reset_m_last", 64'(m_last), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        checkOutput("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // First word latency and lane ordering
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("latency_early", 64'(m_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("latency_valid", 64'(m_valid), 64'd1);
        checkOutput("first_word", m_data, 64'h0003_0002_0001_0000);
        checkOutput("first_last", 64'(m_last), 64'd0);

        // Continuous ramp with packet framing
        ramp = 16'd4;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, 1'b1, ramp, 1'b1);
            ramp++;
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);

        // Back-pressure: fill the FIFO and drop four words
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b1, 1'b1, ramp, 1'b0);
            ramp++;
        end
        repeat (2) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("overflow_set", 64'(overflow), 64'd1);
        checkOutput("drop_cnt_four", 64'(drop_cnt), 64'd4);

        // Full FIFO with sparse ready pulses
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, 1'b1, ramp, 1'(k % 5 == 0));
            ramp++;
        end
        repeat (40) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);

        // Enable gap discards a partial word
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 16'hAA00 + 16'(i), 1'b1);
        applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'hBB00 + 16'(i), 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(15) != 0), 1'($urandom_range(7) != 0),
                          16'($urandom), 1'($urandom_range(2) != 0));
        end
        repeat (40) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);

        // Reset with five queued words and a partial word pending
        for (int i = 0; i < 22; i++) begin
            applyStimulus(1'b1, 1'b1, ramp, 1'b0);
            ramp++;
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("queued_valid", 64'(m_valid), 64'd1);
        #3 reset = 1'b0;
        #1;
        checkOutput("async_m_valid", 64'(m_valid), 64'd0);
        checkOutput("async_m_data", m_data, 64'd0);
        checkOutput("async_overflow", 64'(overflow), 64'd0);
        checkOutput("async_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'hC000 + 16'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("post_reset_word", m_data, 64'hC003_C002_C001_C000);
        repeat (10) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
        $finish;
    end

endmodule
